// File: rtl/program_loader_if.sv
// Stream-in / memory-write bundle between an upstream byte feeder, the
// program_loader and the CPU memory port.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_err;

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream loader for the CPU's memory: SYNC, ADDR, COUNT, payload.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module program_loader #(
  parameter int                    ADDR_WIDTH     = 5,
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = 8'hA5,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input logic             clock,
  input logic             reset,
  program_loader_if.slave bus
);

  localparam int CW = ((DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_LEN = CW'(1) << ADDR_WIDTH;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CW-1:0]         rem;
  logic [TW-1:0]         tmo;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
`endif

  logic ready;
  logic fire;
  logic framing;
  logic timeout;

  always_comb begin
    ready   = (state != S_DONE) && (state != S_ERR);
    fire    = bus.in_valid && ready;
    framing = (state == S_ADDR) || (state == S_COUNT) ||
              (state == S_DATA) || (state == S_CHECK);
    timeout = framing && !fire && (tmo == TMO_LAST);
  end

  assign bus.in_ready  = ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = framing;
  assign bus.load_done = (state == S_DONE);
  assign bus.load_err  = err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      addr        <= '0;
      rem         <= '0;
      tmo         <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      // Idle counter only runs inside a frame and restarts on every transfer.
      if (framing && !fire) tmo <= tmo + TW'(1);
      else                  tmo <= '0;

      if (timeout) begin
        state <= S_ERR;
        err_q <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (fire && (bus.in_data == SYNC_BYTE)) begin
              state <= S_ADDR;
              err_q <= 1'b0;
            end
          end
          S_ADDR: begin
            if (fire) begin
              addr  <= bus.in_data[ADDR_WIDTH-1:0];
              state <= S_COUNT;
`ifdef LOADER_CHECKSUM_EN
              csum  <= bus.in_data;
`endif
            end
          end
          S_COUNT: begin
            if (fire) begin
              rem   <= (bus.in_data == '0) ? FULL_LEN : CW'(bus.in_data);
              state <= S_DATA;
`ifdef LOADER_CHECKSUM_EN
              csum  <= csum ^ bus.in_data;
`endif
            end
          end
          S_DATA: begin
            if (fire) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr;
              mem_wdata_q <= bus.in_data;
              addr        <= addr + ADDR_WIDTH'(1);
              rem         <= rem - CW'(1);
`ifdef LOADER_CHECKSUM_EN
              csum        <= csum ^ bus.in_data;
              if (rem == CW'(1)) state <= S_CHECK;
`else
              if (rem == CW'(1)) state <= S_DONE;
`endif
            end
          end
`ifdef LOADER_CHECKSUM_EN
          S_CHECK: begin
            if (fire) begin
              if (bus.in_data == csum) begin
                state <= S_DONE;
              end else begin
                state <= S_ERR;
                err_q <= 1'b1;
              end
            end
          end
`endif
          S_DONE:  state <= S_IDLE;
          S_ERR:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
